switch_output_arbiter: RTL and testbench
========================================

# switch_output_arbiter

Crossbar scheduler for the 4x4 switch. It sits directly downstream of the four per-input packet queues. Each cycle it inspects the queue head words, grants each output port to at most one requesting input by round-robin, pops the granted queues, and registers the selected words onto the four output ports. Output ports support backpressure.

## Interface
Parameters:
- none. Word width is fixed at 33 bits and the port count is fixed at 4.

Ports:
- `clk`  in  1  — single clock, rising edge.
- `rst`  in  1  — asynchronous, active-low reset.
- `in_data`  in  132  — queue head words; input i is `in_data[33*i+32 : 33*i]`.
  - Word format: bit 32 = valid, [31:30] = destination port, [29:0] = payload.
  - An empty queue presents all zeros.
- `q_rd_en`  out  4  — pop strobe, bit i to queue i. Combinational; the queue pops on the same `clk` edge.
- `out_data`  out  132  — registered output word per port j, in the same 33-bit format, same slicing.
- `out_valid`  out  4  — bit j: `out_data` slice j holds a word.
- `out_ready`  in  4  — bit j: the port-j consumer accepts a word on this edge.

## Operation
- Request: input i requests port j when `in_data[i][32]==1` and `in_data[i][31:30]==j`. Each input requests at most one port per cycle, so grants never conflict across ports.
- Port j is open when `!out_valid[j] || out_ready[j]`.
- Arbitration for port j:
  - Runs only when port j is open.
  - Candidates are the inputs requesting j, searched in order `rr_ptr[j]`, `rr_ptr[j]+1`, … modulo 4.
  - The first candidate found wins.
- `q_rd_en[i]` = 1 only if input i won some port this cycle. It is forced to 0 while `rst==0`.
- On `posedge clk`, for each port j:
  - Grant to input i: `out_data[j] <= in_data[i]`, `out_valid[j] <= 1`, `rr_ptr[j] <= (i+1) mod 4`.
  - No grant and `out_ready[j]==1`: `out_valid[j] <= 0`. `out_data[j]` is don't-care but holds its value.
  - No grant and port not open: hold `out_data[j]` and `out_valid[j]`. `rr_ptr[j]` is unchanged.
- `rr_ptr` is 2 bits per port and wraps 3 -> 0 naturally.
- A word is transferred to the consumer on an edge where `out_valid[j] && out_ready[j]`.
- The block never drops, duplicates or reorders words from the same input.
- Head-of-line blocking is accepted: a stalled head blocks its own queue only.
- Invalid heads (bit 32 = 0) are never popped, even if the upper bits are nonzero.

## Timing
- Reset (`rst` low, asynchronous): `out_valid=0`, `out_data=0`, every `rr_ptr=0`, `q_rd_en=0`. Takes effect immediately without a clock edge.
- Reset deassertion: the first arbitration happens on the first rising edge with `rst==1`.
- Reset asserted mid-operation: registered words in flight are discarded. No pop is issued during reset.
- Latency: a head word is popped and appears on `out_data` at the same edge, so the queue head is visible on the output 1 cycle after it is presented.
- Throughput: 1 word per port per cycle with `out_ready` held high, i.e. 4 words per cycle aggregate when destinations are disjoint.
- Simultaneous accept and refill: when `out_valid[j]==1` and `out_ready[j]==1`, a new grant in the same cycle loads the next word with no bubble.
- Backpressure: `out_ready[j]==0` with `out_valid[j]==1` holds the word. Port j grants nothing, so the requesting queues are not popped.
- `out_ready` is sampled only at the edge. `q_rd_en` depends combinationally on `out_ready` and `in_data`.
- Fairness: with N persistent requesters on one port, each is served at least once every N grants of that port.

## Test plan
- **Reset:** hold `rst=0` with nonzero `in_data`.
  - Required: `q_rd_en=0`, `out_valid=0`, `out_data=0`.
  - Release; the first edge grants.
- **Single path:** input 2 head `{1,2'd1,30'h0000_00AA}`, `out_ready=4'hF`.
  - Required: `q_rd_en=4'b0100` that cycle.
  - Next cycle: `out_valid=4'b0010`, `out_data` slice 1 = `33'h1_4000_00AA`.
- **Contention:** all four inputs target port 0 continuously, `out_ready=4'hF`.
  - Required: grants in order 0,1,2,3,0 on consecutive cycles, one `q_rd_en` bit per cycle.
- **Parallel:** input i targets port (3-i).
  - Required: `q_rd_en=4'hF` on one edge.
  - Next cycle: `out_valid=4'hF` with crossed data.
- **Backpressure:** port 3 holds a word and `out_ready[3]=0` for 5 cycles while input 1 requests port 3.
  - Required: `q_rd_en[1]=0` and `out_data` slice 3 stable for all 5 cycles.
  - Raise ready: the word transfers and input 1 is granted on the same edge.
- **Empty/invalid:** all-zero heads, plus one head `{0,2'd2,30'h3FFF_FFFF}`.
  - Required: no pops, and `out_valid` drops to 0 after the last accepted word.

Source files
------------

// File: rtl/switch_output_arbiter_if.sv
// Queue-head / output-port bundle for the 4x4 output arbiter; 33-bit words packed 4-wide.
// master = arbiter side, slave = queues plus output consumers.
interface switch_output_arbiter_if;
    logic [131:0] in_data;
    logic [3:0]   q_rd_en;
    logic [131:0] out_data;
    logic [3:0]   out_valid;
    logic [3:0]   out_ready;

    modport master (
        input  in_data,
        input  out_ready,
        output q_rd_en,
        output out_data,
        output out_valid
    );

    modport slave (
        output in_data,
        output out_ready,
        input  q_rd_en,
        input  out_data,
        input  out_valid
    );
endinterface

// File: rtl/switch_output_arbiter.sv
// 4x4 crossbar scheduler: per-port round-robin grant, pop and register; head visible 1 cycle later.
// A port holding an unaccepted word grants nothing, so its requesting queues are not popped.
module switch_output_arbiter (
    input  logic                    clk,
    input  logic                    rst,
    switch_output_arbiter_if.master bus
);

    logic [3:0]       out_valid_q, out_valid_d;
    logic [131:0]     out_data_q, out_data_d;
    logic [3:0][1:0]  rr_ptr_q, rr_ptr_d;
    logic [3:0][3:0]  req;        // req[i][j]: input i wants port j
    logic [3:0]       grant_in;

    always_comb begin
        req = '0;
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                req[i][j] = bus.in_data[33*i+32] && (bus.in_data[33*i+30 +: 2] == 2'(j));
            end
        end
    end

    always_comb begin
        logic       port_open;
        logic       found;
        logic [1:0] win;
        logic [1:0] idx;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        rr_ptr_d    = rr_ptr_q;
        grant_in    = '0;
        port_open   = 1'b0;
        found       = 1'b0;
        win         = 2'd0;
        idx         = 2'd0;
        for (int j = 0; j < 4; j++) begin
            port_open = !out_valid_q[j] || bus.out_ready[j];
            found     = 1'b0;
            win       = 2'd0;
            // Search starts at the pointer and wraps through the 2-bit index.
            for (int k = 0; k < 4; k++) begin
                idx = rr_ptr_q[j] + 2'(k);
                if (!found && req[idx][j]) begin
                    found = 1'b1;
                    win   = idx;
                end
            end
            if (port_open && found) begin
                grant_in[win]           = 1'b1;
                out_data_d[33*j +: 33]  = bus.in_data[33*int'(win) +: 33];
                out_valid_d[j]          = 1'b1;
                rr_ptr_d[j]             = win + 2'd1;
            end else if (bus.out_ready[j]) begin
                out_valid_d[j] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q <= '0;
            out_data_q  <= '0;
            rr_ptr_q    <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            rr_ptr_q    <= rr_ptr_d;
        end
    end

    // Pops are suppressed while reset is held so no queue loses a word.
    assign bus.q_rd_en   = rst ? grant_in : 4'b0000;
    assign bus.out_data  = out_data_q;
    assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_switch_output_arbiter.sv
// Directed bench for switch_output_arbiter: inputs driven and outputs sampled on the falling edge.
module tb_switch_output_arbiter;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    switch_output_arbiter_if bus ();

    switch_output_arbiter dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [32:0] w(input logic v, input logic [1:0] d, input logic [29:0] p);
        return {v, d, p};
    endfunction

    task automatic do_reset();
        rst_n         = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 4'hF;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        logic [32:0] wa;
        wa = w(1'b1, 2'd0, 30'h0000_0055);
        rst_n         = 1'b0;
        bus.out_ready = 4'hF;
        bus.in_data   = '0;
        bus.in_data[32:0] = wa;
        bus.in_data[33 +: 33] = w(1'b1, 2'd2, 30'h1);
        #1;
        n_tests++; if (bus.q_rd_en !== 4'b0000) begin n_fail++; $display("FAIL reset_q_rd_en got=%b exp=0000", bus.q_rd_en); end
        n_tests++; if (bus.out_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0000", bus.out_valid); end
        n_tests++; if (bus.out_data !== 132'd0) begin n_fail++; $display("FAIL reset_out_data got=%h exp=0", bus.out_data); end
        repeat (2) @(negedge clk);
        n_tests++; if (bus.q_rd_en !== 4'b0000) begin n_fail++; $display("FAIL reset_hold_q_rd_en got=%b exp=0000", bus.q_rd_en); end
        n_tests++; if (bus.out_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_hold_out_valid got=%b exp=0000", bus.out_valid); end
        rst_n = 1'b1;
        #1;
        n_tests++; if (bus.q_rd_en !== 4'b0011) begin n_fail++; $display("FAIL release_q_rd_en got=%b exp=0011", bus.q_rd_en); end
        @(negedge clk);
        n_tests++; if (bus.out_valid !== 4'b0101) begin n_fail++; $display("FAIL release_out_valid got=%b exp=0101", bus.out_valid); end
        n_tests++; if (bus.out_data[32:0] !== wa) begin n_fail++; $display("FAIL release_slice0 got=%h exp=%h", bus.out_data[32:0], wa); end
        // Asynchronous assertion away from any clock edge.
        #2 rst_n = 1'b0;
        #1;
        n_tests++; if (bus.out_valid !== 4'b0000) begin n_fail++; $display("FAIL async_rst_out_valid got=%b exp=0000", bus.out_valid); end
        n_tests++; if (bus.out_data !== 132'd0) begin n_fail++; $display("FAIL async_rst_out_data got=%h exp=0", bus.out_data); end
        n_tests++; if (bus.q_rd_en !== 4'b0000) begin n_fail++; $display("FAIL async_rst_q_rd_en got=%b exp=0000", bus.q_rd_en); end
    endtask

    task automatic test_single_path();
        do_reset();
        bus.in_data[66 +: 33] = w(1'b1, 2'd1, 30'h0000_00AA);
        #1;
        n_tests++; if (bus.q_rd_en !== 4'b0100) begin n_fail++; $display("FAIL single_q_rd_en got=%b exp=0100", bus.q_rd_en); end
        @(negedge clk);
        bus.in_data = '0;
        n_tests++; if (bus.out_valid !== 4'b0010) begin n_fail++; $display("FAIL single_out_valid got=%b exp=0010", bus.out_valid); end
        n_tests++; if (bus.out_data[33 +: 33] !== 33'h1_4000_00AA) begin n_fail++; $display("FAIL single_slice1 got=%h exp=1400000aa", bus.out_data[33 +: 33]); end
        @(negedge clk);
        n_tests++; if (bus.out_valid !== 4'b0000) begin n_fail++; $display("FAIL single_drain got=%b exp=0000", bus.out_valid); end
    endtask

    task automatic test_contention();
        int e;
        do_reset();
        for (int i = 0; i < 4; i++) bus.in_data[33*i +: 33] = w(1'b1, 2'd0, 30'(32'h100 + i));
        for (int c = 0; c < 5; c++) begin
            e = c % 4;
            #1;
            n_tests++; if (bus.q_rd_en !== 4'(1 << e)) begin n_fail++; $display("FAIL contention_q_rd_en cyc=%0d got=%b exp=%b", c, bus.q_rd_en, 4'(1 << e)); end
            @(negedge clk);
            n_tests++; if (bus.out_valid !== 4'b0001) begin n_fail++; $display("FAIL contention_out_valid cyc=%0d got=%b exp=0001", c, bus.out_valid); end
            n_tests++; if (bus.out_data[32:0] !== w(1'b1, 2'd0, 30'(32'h100 + e))) begin n_fail++; $display("FAIL contention_slice0 cyc=%0d got=%h exp=%h", c, bus.out_data[32:0], w(1'b1, 2'd0, 30'(32'h100 + e))); end
        end
        bus.in_data = '0;
    endtask

    task automatic test_parallel();
        do_reset();
        for (int i = 0; i < 4; i++) bus.in_data[33*i +: 33] = w(1'b1, 2'(3 - i), 30'(32'h200 + i));
        #1;
        n_tests++; if (bus.q_rd_en !== 4'hF) begin n_fail++; $display("FAIL parallel_q_rd_en got=%b exp=1111", bus.q_rd_en); end
        @(negedge clk);
        bus.in_data = '0;
        n_tests++; if (bus.out_valid !== 4'hF) begin n_fail++; $display("FAIL parallel_out_valid got=%b exp=1111", bus.out_valid); end
        for (int j = 0; j < 4; j++) begin
            n_tests++; if (bus.out_data[33*j +: 33] !== w(1'b1, 2'(j), 30'(32'h200 + 3 - j))) begin n_fail++; $display("FAIL parallel_slice%0d got=%h exp=%h", j, bus.out_data[33*j +: 33], w(1'b1, 2'(j), 30'(32'h200 + 3 - j))); end
        end
    endtask

    task automatic test_backpressure();
        logic [32:0] wa, wb;
        wa = w(1'b1, 2'd3, 30'h0AAA_0001);
        wb = w(1'b1, 2'd3, 30'h0BBB_0002);
        do_reset();
        bus.out_ready = 4'b0111;
        bus.in_data[32:0] = wa;
        #1;
        n_tests++; if (bus.q_rd_en !== 4'b0001) begin n_fail++; $display("FAIL bp_first_q_rd_en got=%b exp=0001", bus.q_rd_en); end
        @(negedge clk);
        bus.in_data = '0;
        bus.in_data[33 +: 33] = wb;
        for (int c = 0; c < 5; c++) begin
            #1;
            n_tests++; if (bus.q_rd_en !== 4'b0000) begin n_fail++; $display("FAIL bp_stall_q_rd_en cyc=%0d got=%b exp=0000", c, bus.q_rd_en); end
            n_tests++; if (bus.out_data[99 +: 33] !== wa || bus.out_valid !== 4'b1000) begin n_fail++; $display("FAIL bp_hold cyc=%0d got=%h/%b exp=%h/1000", c, bus.out_data[99 +: 33], bus.out_valid, wa); end
            @(negedge clk);
        end
        bus.out_ready = 4'hF;
        #1;
        n_tests++; if (bus.q_rd_en !== 4'b0010) begin n_fail++; $display("FAIL bp_release_q_rd_en got=%b exp=0010", bus.q_rd_en); end
        @(negedge clk);
        bus.in_data = '0;
        n_tests++; if (bus.out_data[99 +: 33] !== wb || bus.out_valid !== 4'b1000) begin n_fail++; $display("FAIL bp_refill got=%h/%b exp=%h/1000", bus.out_data[99 +: 33], bus.out_valid, wb); end
    endtask

    task automatic test_empty_invalid();
        logic [32:0] wc;
        wc = w(1'b1, 2'd2, 30'h0000_0123);
        do_reset();
        bus.in_data[32:0] = wc;
        #1;
        n_tests++; if (bus.q_rd_en !== 4'b0001) begin n_fail++; $display("FAIL empty_first_q_rd_en got=%b exp=0001", bus.q_rd_en); end
        @(negedge clk);
        bus.in_data = '0;
        bus.in_data[99 +: 33] = w(1'b0, 2'd2, 30'h3FFF_FFFF);
        #1;
        n_tests++; if (bus.out_valid !== 4'b0100 || bus.out_data[66 +: 33] !== wc) begin n_fail++; $display("FAIL empty_last_word got=%h/%b exp=%h/0100", bus.out_data[66 +: 33], bus.out_valid, wc); end
        for (int c = 0; c < 4; c++) begin
            #1;
            n_tests++; if (bus.q_rd_en !== 4'b0000) begin n_fail++; $display("FAIL invalid_q_rd_en cyc=%0d got=%b exp=0000", c, bus.q_rd_en); end
            @(negedge clk);
            n_tests++; if (bus.out_valid !== 4'b0000) begin n_fail++; $display("FAIL empty_out_valid cyc=%0d got=%b exp=0000", c, bus.out_valid); end
        end
        bus.in_data = '0;
    endtask

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        rst_n         = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 4'hF;
        @(negedge clk);
        test_reset();
        test_single_path();
        test_contention();
        test_parallel();
        test_backpressure();
        test_empty_invalid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
